// File: rtl/keypad_debounce_pkg.sv
// Shared definitions for the keypad debounce block: state encoding,
// key-code width and a counter width helper.
package keypad_debounce_pkg;

    // Width of the key code delivered by keypad_scan
    localparam int KEY_W = 4;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Number of bits needed to hold values 0..max_val (at least 1)
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small FIFO of key events with a registered head output, simultaneous
// push/pop support and a sticky overflow flag for dropped events.
module key_event_fifo
    import keypad_debounce_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int KEY_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [KEY_W-1:0]         data_in,
    input  logic                     pop,
    output logic [KEY_W-1:0]         data_out,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

    logic [KEY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic             do_push;
    logic             do_pop;
    logic             drop;
    logic [KEY_W-1:0] head_nxt;
    logic [PTR_W:0]   count_nxt;

    assign valid = (count != '0);

    // Decide which operations take effect and what the next head will be
    always_comb begin
        do_pop     = pop && (count != '0);
        do_push    = push && ((count != CNT_FULL) || do_pop);
        drop       = push && (count == CNT_FULL) && !do_pop;
        rd_ptr_inc = rd_ptr + PTR_W'(1);
        head_nxt   = data_out;
        count_nxt  = count;
        // A push into an empty (or just-emptied) FIFO becomes the head directly
        if (do_pop) begin
            if (count == CNT_ONE) begin
                head_nxt = do_push ? data_in : '0;
            end else begin
                head_nxt = mem[rd_ptr_inc];
            end
        end else if (do_push && (count == '0)) begin
            head_nxt = data_in;
        end
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy, head register and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count    <= count_nxt;
            data_out <= head_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Event storage; contents need no reset since occupancy gates them
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: rtl/keypad_debounce.sv
// Debounces the raw key/pressed pair from keypad_scan into key-press events,
// optionally generating auto-repeat events, and queues them for keypad_FSM.
module keypad_debounce
    import keypad_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_EN    = 0,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 8,
    parameter int DEPTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             key_in,
    input  logic                   pressed_in,
    input  logic                   pop,
    output logic [3:0]             key_out,
    output logic                   key_valid,
    output logic                   held,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int CNT_W   = cnt_width(DEBOUNCE_CNT);
    localparam int RPT_MAX = REPEAT_DELAY + REPEAT_RATE;
    localparam int RPT_W   = cnt_width(RPT_MAX);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);
    localparam logic [RPT_W-1:0] RPT_DELAY_V = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_MAX_V   = RPT_W'(RPT_MAX);

    state_t           state;
    state_t           state_nxt;
    logic [KEY_W-1:0] candidate;
    logic [KEY_W-1:0] cand_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [RPT_W-1:0] rpt;
    logic [RPT_W-1:0] rpt_nxt;
    logic [RPT_W-1:0] rpt_inc;
    logic             match;
    logic             push_evt;

    assign match = pressed_in && (key_in == candidate);
    assign held  = (state == HELD) || (state == RELEASE);

    // Next-state, debounce/repeat counters and event push decision
    always_comb begin
        state_nxt = state;
        cand_nxt  = candidate;
        cnt_nxt   = cnt;
        rpt_nxt   = rpt;
        push_evt  = 1'b0;
        // Saturating increment so a long hold never wraps into a false repeat
        rpt_inc   = (rpt == RPT_MAX_V) ? rpt : rpt + RPT_ONE;
        case (state)
            IDLE: begin
                if (pressed_in) begin
                    state_nxt = CONFIRM;
                    cand_nxt  = key_in;
                    cnt_nxt   = CNT_ONE;
                end
            end
            CONFIRM: begin
                if (!pressed_in) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (key_in != candidate) begin
                    cand_nxt = key_in;
                    cnt_nxt  = CNT_ONE;
                end else if (cnt == CNT_LAST) begin
                    push_evt  = 1'b1;
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    rpt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!match) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = CNT_ONE;
                end else if ((REPEAT_EN != 0) && (rpt_inc == RPT_DELAY_V)) begin
                    push_evt = 1'b1;
                    rpt_nxt  = rpt_inc;
                end else if ((REPEAT_EN != 0) && (rpt_inc == RPT_MAX_V)) begin
                    // Fold back to the delay point so the next repeat is one rate period away
                    push_evt = 1'b1;
                    rpt_nxt  = RPT_DELAY_V;
                end else begin
                    rpt_nxt = rpt_inc;
                end
            end
            RELEASE: begin
                if (match) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    rpt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
        endcase
    end

    // FSM state, candidate key and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            candidate <= '0;
            cnt       <= '0;
            rpt       <= '0;
        end else begin
            state     <= state_nxt;
            candidate <= cand_nxt;
            cnt       <= cnt_nxt;
            rpt       <= rpt_nxt;
        end
    end

    key_event_fifo #(
        .DEPTH (DEPTH),
        .KEY_W (KEY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_evt),
        .data_in  (candidate),
        .pop      (pop),
        .data_out (key_out),
        .valid    (key_valid),
        .count    (count),
        .overflow (overflow)
    );

endmodule
